// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg
//   Shared definitions for the pipe_stage register slice.
//   - state_e     : occupancy state, encoding equals entries held (0..2)
//   - *_W         : default payload field widths and their sum PAYLOAD_W
//   - payload_t   : payload layout, MSB first
//   - pack_payload: builds a payload vector from its fields in layout order
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int unsigned JUMP_ADDR_W = 32;
  localparam int unsigned RESULT_W    = 32;
  localparam int unsigned ZERO_W      = 1;
  localparam int unsigned RDATA2_W    = 32;
  localparam int unsigned WADDR_W     = 5;
  localparam int unsigned PAYLOAD_W   = JUMP_ADDR_W + RESULT_W + ZERO_W + RDATA2_W + WADDR_W;

  typedef struct packed {
    logic [JUMP_ADDR_W-1:0] jump_addr;
    logic [RESULT_W-1:0]    result;
    logic [ZERO_W-1:0]      zero;
    logic [RDATA2_W-1:0]    rdata2;
    logic [WADDR_W-1:0]     waddr;
  } payload_t;

  // Field order here is the single definition of the wire layout.
  function automatic logic [PAYLOAD_W-1:0] pack_payload(
    input logic [JUMP_ADDR_W-1:0] jump_addr,
    input logic [RESULT_W-1:0]    result,
    input logic [ZERO_W-1:0]      zero,
    input logic [RDATA2_W-1:0]    rdata2,
    input logic [WADDR_W-1:0]     waddr
  );
    payload_t p;
    p.jump_addr = jump_addr;
    p.result    = result;
    p.zero      = zero;
    p.rdata2    = rdata2;
    p.waddr     = waddr;
    return p;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage
//   Valid/ready pipeline register slice with optional skid entry.
//   SKID=1: two entries (main + skid), in_ready comes straight from a flop so
//           there is no combinational path from out_ready to in_ready.
//   SKID=0: single entry, in_ready = out_ready || !out_valid.
// Ports
//   clk, rst (async, active-low)       clock and reset
//   flush                              synchronous kill of all contents
//   in_valid / in_ready / in_data      upstream handshake and payload
//   out_valid / out_ready / out_data   downstream handshake and payload (main entry)
//   occ                                entries held (0..2)
//   stall_cnt / stall_clr              saturating stall counter and its clear
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int unsigned DATA_W = PAYLOAD_W,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  main_q,  main_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               accept_in;
  logic               accept_out;

  assign out_valid  = (state_q != ST_EMPTY);
  assign accept_in  = in_valid && in_ready;
  assign accept_out = out_valid && out_ready;
  assign out_data   = main_q;
  assign occ        = state_q;
  assign stall_cnt  = stall_cnt_q;

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] skid_q, skid_d;
      logic              in_ready_q, in_ready_d;

      assign in_ready = in_ready_q;

      // Next state and entry loads for the two-entry stage.
      always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        if (flush) begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (accept_in) begin
                main_d  = in_data;
                state_d = ST_ONE;
              end else begin
                state_d = ST_EMPTY;
              end
            end
            ST_ONE: begin
              if (accept_in && accept_out) begin
                main_d  = in_data;
                state_d = ST_ONE;
              end else if (accept_in) begin
                skid_d  = in_data;
                state_d = ST_FULL;
              end else if (accept_out) begin
                state_d = ST_EMPTY;
              end else begin
                state_d = ST_ONE;
              end
            end
            ST_FULL: begin
              // in_ready is low here, so only the drain can happen.
              if (accept_out) begin
                main_d  = skid_q;
                state_d = ST_ONE;
              end else begin
                state_d = ST_FULL;
              end
            end
            default: begin
              state_d = ST_EMPTY;
              main_d  = '0;
              skid_d  = '0;
            end
          endcase
        end
        // Registered ready: decided from the next state, not from out_ready.
        in_ready_d = (state_d != ST_FULL);
      end

      // Skid entry and registered in_ready.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          skid_q     <= '0;
          in_ready_q <= 1'b1;
        end else begin
          skid_q     <= skid_d;
          in_ready_q <= in_ready_d;
        end
      end
    end else begin : g_single
      assign in_ready = out_ready || !out_valid;

      // Next state and main load for the single-entry stage.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
          state_d = ST_EMPTY;
          main_d  = '0;
        end else if (accept_in) begin
          main_d  = in_data;
          state_d = ST_ONE;
        end else if (accept_out) begin
          state_d = ST_EMPTY;
        end else if (state_q == ST_FULL) begin
          // Unreachable without a skid entry; recover to a legal state.
          state_d = ST_EMPTY;
        end else begin
          state_d = state_q;
        end
      end
    end
  endgenerate

  // Saturating stall counter; clear beats increment, flush does not touch it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, main entry and stall counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
module tb_pipe_stage;
  import pipe_stage_pkg::*;

  localparam int W = 102;

  logic         clk;
  logic         rst;

  // DUT a: SKID=1, CNT_W=4
  logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_stall_clr;
  logic [W-1:0] a_in_data, a_out_data;
  logic [1:0]   a_occ;
  logic [3:0]   a_stall_cnt;

  // DUT b: SKID=0, CNT_W=16
  logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stall_clr;
  logic [W-1:0] b_in_data, b_out_data;
  logic [1:0]   b_occ;
  logic [15:0]  b_stall_cnt;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  pipe_stage #(.DATA_W(W), .SKID(1), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occ(a_occ), .stall_cnt(a_stall_cnt), .stall_clr(a_stall_clr)
  );

  pipe_stage #(.DATA_W(W), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occ(b_occ), .stall_cnt(b_stall_cnt), .stall_clr(b_stall_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard/monitor for DUT a: push on input handshake, pop on output handshake.
  always @(negedge clk) begin
    if (!rst || a_flush) begin
      qa.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected_out actual=%0h required=none", a_out_data);
        end else begin
          check("a_out_order", a_out_data, qa.pop_front());
        end
      end
      if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
    end
  end

  // Scoreboard/monitor for DUT b.
  always @(negedge clk) begin
    if (!rst || b_flush) begin
      qb.delete();
    end else begin
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_out actual=%0h required=none", b_out_data);
        end else begin
          check("b_out_order", b_out_data, qb.pop_front());
        end
      end
      if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] vec [6];
    logic [31:0]  pat;
    int           idx;
    int           b_acc;
    logic         acc;

    rst = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_stall_clr = 1'b0; a_in_data = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_stall_clr = 1'b0; b_in_data = '0;

    step(); step();
    check("rst_occ",       W'(a_occ), W'(0));
    check("rst_out_valid", W'(a_out_valid), W'(0));
    check("rst_out_data",  a_out_data, W'(0));
    check("rst_stall",     W'(a_stall_cnt), W'(0));
    check("rst_in_ready",  W'(a_in_ready), W'(1));
    rst = 1'b1;
    step();
    check("rel_in_ready",  W'(a_in_ready), W'(1));

    // Single transfer, one-edge latency.
    a_in_valid = 1'b1; a_in_data = W'(1); a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    check("lat_out_valid", W'(a_out_valid), W'(1));
    check("lat_out_data",  a_out_data, W'(1));
    check("lat_occ1",      W'(a_occ), W'(1));
    step();
    check("lat_occ0",      W'(a_occ), W'(0));
    check("empty_hold",    a_out_data, W'(1));

    // Back-pressure fill: 1,2 captured, 3 held upstream.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = W'(1);
    step();
    a_in_data = W'(2);
    step();
    check("full_occ",      W'(a_occ), W'(2));
    check("full_in_ready", W'(a_in_ready), W'(0));
    a_in_data = W'(3);
    step();
    check("full_hold_occ", W'(a_occ), W'(2));
    check("full_hold_data", a_out_data, W'(1));
    // Drain from FULL with in_valid high: skid moves to main, input not taken.
    a_out_ready = 1'b1;
    step();
    check("drain_data2",   a_out_data, W'(2));
    check("drain_occ1",    W'(a_occ), W'(1));
    check("drain_ready",   W'(a_in_ready), W'(1));
    step();
    check("drain_data3",   a_out_data, W'(3));
    a_in_valid = 1'b0;
    step();
    check("drain_empty",   W'(a_occ), W'(0));

    // Flush while FULL with a pending input.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = W'(12'hA0A);
    step();
    a_in_data = W'(12'hB0B);
    step();
    a_in_data = W'(12'hC0C); a_flush = 1'b1;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    check("flush_occ",       W'(a_occ), W'(0));
    check("flush_out_valid", W'(a_out_valid), W'(0));
    check("flush_out_data",  a_out_data, W'(0));
    check("flush_in_ready",  W'(a_in_ready), W'(1));
    step();
    check("flush_no_capture", W'(a_occ), W'(0));

    // Stall counter saturation, clear priority, async reset mid-stall.
    a_stall_clr = 1'b1;
    step();
    a_stall_clr = 1'b0;
    check("stall_clr0", W'(a_stall_cnt), W'(0));
    a_in_valid = 1'b1; a_in_data = W'(8'h55);
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 2) check("stall_cnt3", W'(a_stall_cnt), W'(3));
    end
    check("stall_sat", W'(a_stall_cnt), W'(15));
    a_stall_clr = 1'b1;
    step();
    check("stall_clr_wins", W'(a_stall_cnt), W'(0));
    a_stall_clr = 1'b0;
    step();
    check("stall_restart", W'(a_stall_cnt), W'(1));
    rst = 1'b0;
    #2;
    check("arst_occ",       W'(a_occ), W'(0));
    check("arst_out_valid", W'(a_out_valid), W'(0));
    check("arst_out_data",  a_out_data, W'(0));
    check("arst_stall",     W'(a_stall_cnt), W'(0));
    check("arst_in_ready",  W'(a_in_ready), W'(1));
    step(); step();
    rst = 1'b1;
    step();

    // Burst of wide payloads under an irregular out_ready pattern.
    vec[0] = pack_payload(32'hDEADBEEF, 32'h12345678, 1'b1, 32'hCAFEF00D, 5'h1F);
    vec[1] = {W{1'b1}};
    vec[2] = W'(1);
    vec[3] = pack_payload(32'h00000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 5'h00);
    vec[4] = {34{3'b101}};
    vec[5] = pack_payload(32'h00000001, 32'h00000002, 1'b1, 32'h00000003, 5'h04);
    pat = 32'b1011_0010_0111_0001_1100_1010_0011_0110;
    idx = 0;
    for (int i = 0; i < 40; i++) begin
      a_out_ready = pat[i % 32];
      a_in_valid  = (idx < 6);
      a_in_data   = (idx < 6) ? vec[idx] : '0;
      @(negedge clk);
      acc = a_in_valid && a_in_ready;
      step();
      if (acc) idx++;
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    for (int i = 0; i < 10 && a_occ != 2'd0; i++) step();
    step();
    check("burst_accepted", W'(idx), W'(6));
    check("burst_drained",  W'(a_occ), W'(0));
    check("burst_queue",    W'(qa.size()), W'(0));

    // SKID=0: toggling out_ready, in_ready must follow it while holding data.
    b_acc = 0;
    b_in_valid = 1'b1;
    b_in_data  = W'(16'h100);
    for (int i = 0; i < 16; i++) begin
      b_out_ready = i[0];
      @(negedge clk);
      if (b_out_valid) check("b_ready_tracks", W'(b_in_ready), W'(b_out_ready));
      else             check("b_ready_empty",  W'(b_in_ready), W'(1));
      acc = b_in_valid && b_in_ready;
      step();
      if (acc) begin
        b_acc++;
        b_in_data = b_in_data + W'(1);
      end
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    step(); step();
    check("b_accept_count", W'(b_acc), W'(9));
    check("b_drained",      W'(b_occ), W'(0));
    check("b_queue",        W'(qb.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
